// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared types for the "1101" sequence detector controller.
//   ctrl_state_t : controller phases IDLE -> SHIFT -> FLUSH -> DONE
//   det_state_t  : detector states, named by the matched prefix
//   PATTERN      : the detected bit sequence, first bit in [3]
package seq_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} ctrl_state_t;

    typedef enum logic [2:0] {S0, S1, S11, S110, S1101} det_state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_1101_fsm.sv
// seq_1101_fsm: registered Moore detector for overlapping "1101".
// Ports:
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset (to S0)
//   clear : synchronous return to S0, wins over en
//   en    : advance one state on input i when high
//   i     : serial input bit
//   o     : high only in S1101
module seq_1101_fsm
    import seq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic en,
    input  logic i,
    output logic o
);

    det_state_t state_q, state_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S0;
        else        state_q <= state_d;
    end

    // A wrong bit falls back to the longest prefix that is still a suffix.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S0;
        end else if (en) begin
            case (state_q)
                S0:      state_d = (i == PATTERN[3]) ? S1    : S0;
                S1:      state_d = (i == PATTERN[2]) ? S11   : S0;
                S11:     state_d = (i == PATTERN[1]) ? S110  : S11;
                S110:    state_d = (i == PATTERN[0]) ? S1101 : S0;
                S1101:   state_d = i ? S11 : S0;
                default: state_d = S0;
            endcase
        end
    end

    assign o = (state_q == S1101);

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: captures a word on start, serializes it into a "1101"
// detector one bit per clock and reports the overlapping match count.
// Ports:
//   clk, n_rst   : clock / asynchronous active-low reset
//   start        : job request, sampled only in IDLE
//   data_in      : word captured on accepted start
//   busy         : high during SHIFT and FLUSH
//   done         : one-cycle pulse, match_count valid
//   match_count  : matches in the last job, held until next accept
//   serial_out   : bit currently fed to the detector
//   match        : detector output
// Build option: SEQ_CTRL_LSB_FIRST_EN serializes LSB first (default MSB first).
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic                  serial_out,
    output logic                  match
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    ctrl_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ser, det_clear, det_en;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        ser       = 1'b0;
        det_clear = 1'b0;
        det_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    det_clear = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
`ifdef SEQ_CTRL_LSB_FIRST_EN
                ser     = shreg_q[0];
                shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
`else
                ser     = shreg_q[DATA_WIDTH-1];
                shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
`endif
                det_en    = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                // On the first SHIFT cycle match still reflects the cleared detector.
                if (bit_cnt_q != '0 && match && cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (bit_cnt_q == BW'(DATA_WIDTH - 1)) state_d = FLUSH;
            end
            FLUSH: begin
                // Detector output for the final bit becomes visible only here.
                if (match && cnt_q != '1) cnt_d = cnt_q + 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    seq_1101_fsm u_det (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (det_clear),
        .en    (det_en),
        .i     (ser),
        .o     (match)
    );

    assign busy        = (state_q == SHIFT) || (state_q == FLUSH);
    assign done        = (state_q == DONE);
    assign match_count = cnt_q;
    assign serial_out  = ser;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

    localparam int DW = 16;
    localparam int CW = 5;

    logic          clk, n_rst, start;
    logic [DW-1:0] data_in;
    logic          busy, done, serial_out, match;
    logic [CW-1:0] match_count;

    int n_cmp = 0;
    int n_err = 0;

    seq_detect_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .match_count (match_count),
        .serial_out  (serial_out),
        .match       (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit j of the serialized stream.
    function automatic logic ser_bit(input logic [DW-1:0] d, input int j);
`ifdef SEQ_CTRL_LSB_FIRST_EN
        return d[j];
`else
        return d[DW-1-j];
`endif
    endfunction

    // True when stream bits k-4..k-1 spell 1101.
    function automatic logic hit(input logic [DW-1:0] d, input int k);
        if (k < 4) return 1'b0;
        return ser_bit(d, k-4) && ser_bit(d, k-3) && !ser_bit(d, k-2) && ser_bit(d, k-1);
    endfunction

    function automatic int exp_count(input logic [DW-1:0] d);
        int c = 0;
        for (int k = 4; k <= DW; k++) c += int'(hit(d, k));
        if (c > (1 << CW) - 1) c = (1 << CW) - 1;
        return c;
    endfunction

    task automatic check_idle(input string tag, input int cnt);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cnt"}, match_count, cnt);
    endtask

    // Call just after a negedge. j indexes the negedge following edge E0+j.
    task automatic run_job(input logic [DW-1:0] d, input bit noise, input bit keep);
        int ec;
        ec = exp_count(d);
        start = 1'b1;
        data_in = d;
        @(posedge clk);
        for (int j = 0; j <= DW + 1; j++) begin
            @(negedge clk);
            check("busy", busy, (j <= DW) ? 1 : 0);
            check("done", done, (j == DW + 1) ? 1 : 0);
            check("serial", serial_out, (j < DW) ? ser_bit(d, j) : 1'b0);
            check("match", match, hit(d, (j < DW) ? j : DW));
            if (j == 0) check("cnt_clr", match_count, 0);
            if (j == DW + 1) check("cnt_done", match_count, ec);
            start = (noise && j == 5) || (j == DW + 1 && (noise || keep));
            if (noise) data_in = ~d;
        end
        @(negedge clk);
        check_idle("post", ec);
        start = keep;
    endtask

    logic [DW-1:0] dir_tbl [8] = '{16'hD000, 16'hDD00, 16'hC000, 16'h1000,
                                   16'hDB60, 16'hDDDD, 16'hFFFF, 16'h000B};

    initial begin
        n_rst = 1'b1;
        start = 1'b0;
        data_in = '0;

        // Reset asserted mid-clock acts immediately and holds across edges.
        #3 n_rst = 1'b0;
        #1;
        check_idle("rst_now", 0);
        check("rst_match", match, 0);
        check("rst_serial", serial_out, 0);
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst_edge", 0);
        check("rst_edge_match", match, 0);
        @(negedge clk) n_rst = 1'b1;
        #1;
        check_idle("rel", 0);
        @(posedge clk);
        #1;
        check_idle("rel_edge", 0);
        check("rel_match", match, 0);
        @(negedge clk);

        foreach (dir_tbl[i]) run_job(dir_tbl[i], 1'b0, 1'b0);

        // Ignored start pulses during SHIFT and DONE.
        run_job(16'hD000, 1'b1, 1'b0);
        // Back-to-back with start held high; no carry-over.
        run_job(16'h000D, 1'b0, 1'b1);
        run_job(16'hD000, 1'b0, 1'b0);

        // Reset mid-job aborts without done.
        start = 1'b1;
        data_in = 16'hDDDD;
        @(posedge clk);
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_rst = 1'b0;
        #1;
        check_idle("abort", 0);
        check("abort_match", match, 0);
        check("abort_serial", serial_out, 0);
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            check("abort_nodone", done, 0);
        end
        @(negedge clk) n_rst = 1'b1;
        @(negedge clk);
        check_idle("abort_rel", 0);
        run_job(16'hD000, 1'b0, 1'b0);

        // Randomized jobs.
        for (int r = 0; r < 16; r++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            run_job(d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        start = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
